// File: rtl/fclass_fcvt_unit.sv
// Single-cycle binary32 classify / integer-to-float converter.
// One operation per cycle, result and inexact flag registered on the next rising edge.
module fclass_fcvt_unit #(
  parameter int FLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [1:0]      op,
  input  logic [FLEN-1:0] rs1,
  input  logic [FLEN-1:0] rs2,
  output logic [FLEN-1:0] out,
  output logic            nx
);

  typedef enum logic [1:0] {
    OP_FCLASS  = 2'd0,
    OP_FCVT_W  = 2'd1,
    OP_FCVT_WU = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  op_e         op_sel;
  logic        unused_rs2;

  logic        f_sign;
  logic [7:0]  f_exp;
  logic [22:0] f_frac;
  logic [9:0]  class_mask;

  logic        cvt_neg;
  logic [31:0] cvt_mag;
  logic [5:0]  cvt_lzc;
  logic [31:0] cvt_norm;
  logic        cvt_guard;
  logic        cvt_sticky;
  logic        cvt_round_up;
  logic [23:0] cvt_frac_sum;
  logic [7:0]  cvt_exp;
  logic [31:0] cvt_result;
  logic        cvt_nx;

  logic [31:0] out_d, out_q;
  logic        nx_d, nx_q;

  assign op_sel     = op_e'(op);
  assign unused_rs2 = ^rs2;

  // Index of the highest set bit, expressed as a leading-zero count (32 for zero).
  function automatic logic [5:0] count_lz(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 6'(31 - i);
    end
    return n;
  endfunction

  assign f_sign = rs1[31];
  assign f_exp  = rs1[30:23];
  assign f_frac = rs1[22:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    class_mask = '0;
    if (&f_exp) begin
      if (f_frac == '0)  class_mask[f_sign ? 0 : 7] = 1'b1;
      else if (f_frac[22]) class_mask[9] = 1'b1;
      else                 class_mask[8] = 1'b1;
    end else if (f_exp == '0) begin
      if (f_frac == '0) class_mask[f_sign ? 3 : 4] = 1'b1;
      else              class_mask[f_sign ? 2 : 5] = 1'b1;
    end else begin
      class_mask[f_sign ? 1 : 6] = 1'b1;
    end
  end

  // Negating 0x80000000 wraps back to 0x80000000, which is the correct magnitude 2^31.
  always_comb begin
    cvt_neg      = (op_sel == OP_FCVT_W) && rs1[31];
    cvt_mag      = cvt_neg ? (32'd0 - rs1) : rs1;
    cvt_lzc      = count_lz(cvt_mag);
    cvt_norm     = cvt_mag << cvt_lzc;
    cvt_guard    = cvt_norm[7];
    cvt_sticky   = |cvt_norm[6:0];
    cvt_round_up = cvt_guard & (cvt_sticky | cvt_norm[8]);
    cvt_frac_sum = {1'b0, cvt_norm[30:8]} + {23'd0, cvt_round_up};
    // A carry out of the fraction leaves the low 23 bits zero, so only the exponent moves.
    cvt_exp      = 8'd158 - {2'b00, cvt_lzc} + {7'd0, cvt_frac_sum[23]};
    cvt_result   = {cvt_neg, cvt_exp, cvt_frac_sum[22:0]};
    cvt_nx       = cvt_guard | cvt_sticky;
    if (cvt_mag == '0) begin
      cvt_result = '0;
      cvt_nx     = 1'b0;
    end
  end

  always_comb begin
    out_d = '0;
    nx_d  = 1'b0;
    unique case (op_sel)
      OP_FCLASS:             out_d = {22'd0, class_mask};
      OP_FCVT_W, OP_FCVT_WU: begin
        out_d = cvt_result;
        nx_d  = cvt_nx;
      end
      OP_RSVD:               ;
      default:               ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; the reset here is synchronous and active-high.
  always_ff @(posedge clk) begin
    if (resetn) begin
      out_q <= '0;
      nx_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      nx_q  <= nx_d;
    end
  end

  assign out = out_q;
  assign nx  = nx_q;

endmodule

// File: tb/tb_fclass_fcvt_unit.sv
// Self-checking bench for fclass_fcvt_unit: directed vector table, a reset
// sequence mid-stream, and random back-to-back traffic against an arithmetic model.
module tb_fclass_fcvt_unit;

  logic        clk;
  logic        resetn;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] out;
  logic        nx;

  int vectors;
  int miscompares;

  fclass_fcvt_unit #(.FLEN(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .out    (out),
    .nx     (nx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] exp_out;
    logic        exp_nx;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] exp_out, input logic exp_nx);
    vectors++;
    if (out !== exp_out || nx !== exp_nx) begin
      miscompares++;
      $display("FAIL %s: got out=%08h nx=%0b, expected out=%08h nx=%0b",
               name, out, nx, exp_out, exp_nx);
    end
  endtask

  // Present inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input logic rst, input logic [1:0] o, input logic [31:0] a);
    resetn = rst;
    op     = o;
    rs1    = a;
    rs2    = $urandom;
    @(posedge clk);
    #1;
  endtask

  // Reference: classification by value category, conversion by integer division.
  function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                output logic [31:0] r, output logic x);
    logic              neg;
    longint unsigned   m, mant, rem, half;
    int                e, sh, bit_idx;
    logic [7:0]        ex;
    r = '0;
    x = 1'b0;
    if (o == 2'd0) begin
      ex = a[30:23];
      if (ex == 8'hFF)
        bit_idx = (a[22:0] == 0) ? (a[31] ? 0 : 7) : (a[22] ? 9 : 8);
      else if (ex == 8'h00)
        bit_idx = (a[22:0] == 0) ? (a[31] ? 3 : 4) : (a[31] ? 2 : 5);
      else
        bit_idx = a[31] ? 1 : 6;
      r = 32'd1 << bit_idx;
    end else if (o == 2'd1 || o == 2'd2) begin
      neg = (o == 2'd1) && a[31];
      m   = neg ? (64'h1_0000_0000 - longint'(a)) : longint'(a);
      if (m != 0) begin
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e <= 23) begin
          mant = m << (23 - e);
          rem  = 0;
        end else begin
          sh   = e - 23;
          mant = m >> sh;
          rem  = m - (mant << sh);
          half = 64'd1 << (sh - 1);
          if (rem > half || (rem == half && mant[0])) mant++;
          if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e++;
          end
        end
        x = (rem != 0);
        r = {neg, 8'(e + 127), mant[22:0]};
      end
    end
  endfunction

  initial begin
    logic [31:0] eo;
    logic        en;
    logic [1:0]  ro;
    logic [31:0] ra;
    vectors     = 0;
    miscompares = 0;
    resetn = 1'b1;
    op     = 2'd0;
    rs1    = '0;
    rs2    = '0;

    tbl.push_back('{2'd0, 32'hFF800000, 32'h001, 1'b0});
    tbl.push_back('{2'd0, 32'h80000000, 32'h008, 1'b0});
    tbl.push_back('{2'd0, 32'h00000001, 32'h020, 1'b0});
    tbl.push_back('{2'd0, 32'h3F800000, 32'h040, 1'b0});
    tbl.push_back('{2'd0, 32'h7F800000, 32'h080, 1'b0});
    tbl.push_back('{2'd0, 32'h7F800001, 32'h100, 1'b0});
    tbl.push_back('{2'd0, 32'hFFC00000, 32'h200, 1'b0});
    tbl.push_back('{2'd0, 32'hBF800000, 32'h002, 1'b0});
    tbl.push_back('{2'd0, 32'h807FFFFF, 32'h004, 1'b0});
    tbl.push_back('{2'd0, 32'h00000000, 32'h010, 1'b0});
    tbl.push_back('{2'd0, 32'hFF800001, 32'h100, 1'b0});
    tbl.push_back('{2'd1, 32'h00000000, 32'h00000000, 1'b0});
    tbl.push_back('{2'd1, 32'h00000001, 32'h3F800000, 1'b0});
    tbl.push_back('{2'd1, 32'hFFFFFFFF, 32'hBF800000, 1'b0});
    tbl.push_back('{2'd1, 32'h80000000, 32'hCF000000, 1'b0});
    tbl.push_back('{2'd1, 32'd16777217, 32'h4B800000, 1'b1});
    tbl.push_back('{2'd1, 32'd16777219, 32'h4B800002, 1'b1});
    tbl.push_back('{2'd1, 32'h7FFFFFFF, 32'h4F000000, 1'b1});
    tbl.push_back('{2'd2, 32'hFFFFFFFF, 32'h4F800000, 1'b1});
    tbl.push_back('{2'd2, 32'h80000000, 32'h4F000000, 1'b0});
    tbl.push_back('{2'd2, 32'h00000003, 32'h40400000, 1'b0});
    tbl.push_back('{2'd2, 32'h00000000, 32'h00000000, 1'b0});
    tbl.push_back('{2'd3, 32'h3F800000, 32'h00000000, 1'b0});

    // An operation presented alongside reset is discarded.
    step(1'b1, 2'd1, 32'h00000001);
    check("reset_discard", 32'h0, 1'b0);
    step(1'b1, 2'd2, 32'hFFFFFFFF);
    check("reset_hold", 32'h0, 1'b0);

    // First edge with reset released shows that edge's operation.
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, tbl[i].op, tbl[i].rs1);
      check($sformatf("table[%0d]", i), tbl[i].exp_out, tbl[i].exp_nx);
    end

    // Back-to-back mixed ops with a one-cycle reset pulse in the middle.
    step(1'b0, 2'd2, 32'h00000003);
    check("b2b_pre", 32'h40400000, 1'b0);
    step(1'b1, 2'd1, 32'h7FFFFFFF);
    check("b2b_reset", 32'h0, 1'b0);
    step(1'b0, 2'd0, 32'h7F800000);
    check("b2b_post0", 32'h080, 1'b0);
    step(1'b0, 2'd1, 32'h7FFFFFFF);
    check("b2b_post1", 32'h4F000000, 1'b1);
    step(1'b0, 2'd2, 32'hFFFFFFFF);
    check("b2b_post2", 32'h4F800000, 1'b1);

    // Random traffic, biased so small and large magnitudes both appear.
    for (int i = 0; i < 400; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: ra = ra >> $urandom_range(0, 31);
        1: ra = {ra[31], 8'hFF, ra[22:0]};
        2: ra = {ra[31], 8'h00, ra[22:0]};
        default: ;
      endcase
      if ($urandom_range(0, 24) == 0) begin
        step(1'b1, ro, ra);
        check($sformatf("rand_reset[%0d]", i), 32'h0, 1'b0);
      end else begin
        model(ro, ra, eo, en);
        step(1'b0, ro, ra);
        check($sformatf("rand[%0d] op=%0d rs1=%08h", i, ro, ra), eo, en);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fclass_fcvt_unit.md
FCLASS_FCVT_UNIT -- requirements
Module: fclass_fcvt_unit

Interface
REQ-001 Parameter: FLEN, 32, operand/result width; only 32 (binary32) SHALL be supported.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  synchronous, active-high reset (the name is kept from the codebase; polarity is active-high).
REQ-004 op  input  2  operation select: 0 = fclass, 1 = fcvt.s.w, 2 = fcvt.s.wu, 3 = reserved.
REQ-005 rs1  input  32  operand: binary32 for fclass, integer for the conversions.
REQ-006 rs2  input  32  second operand; SHALL be ignored by every operation.
REQ-007 out  output  32  registered result.
REQ-008 nx  output  1  registered inexact flag for the conversions.

Function
REQ-009 Latency SHALL be exactly 1 cycle: out/nx SHALL reflect op/rs1 sampled at the previous rising edge, with a new operation accepted every cycle and no handshake.
REQ-010 fclass SHALL output a one-hot 10-bit mask in out[9:0], with out[31:10]=0, as follows:
- bit0: -inf
- bit1: negative normal
- bit2: negative subnormal
- bit3: -0
- bit4: +0
- bit5: positive subnormal
- bit6: positive normal
- bit7: +inf
- bit8: signaling NaN (exp=0xFF, frac!=0, frac[22]=0)
- bit9: quiet NaN (exp=0xFF, frac[22]=1)
REQ-011 NaN classification SHALL ignore the sign bit; fclass SHALL drive nx=0.
REQ-012 fcvt.s.w SHALL treat rs1 as two's-complement signed and produce the nearest binary32 value.
- Sign is taken from rs1[31]; the magnitude is |rs1|, with -2^31 handled as the magnitude 2^31.
REQ-013 fcvt.s.wu SHALL treat rs1 as unsigned; the result sign SHALL be 0.
REQ-014 Conversion data path SHALL be:
- leading-zero count of the 32-bit magnitude;
- normalize so the MSB is the hidden bit;
- exponent = 127 + (31 - lzc);
- 23-bit fraction from the bits below the hidden bit;
- guard bit = next bit; sticky = OR of all remaining lower bits.
REQ-015 Rounding SHALL be round-to-nearest-ties-to-even only: increment when guard & (sticky | frac LSB).
- A fraction carry-out SHALL increment the exponent and clear the fraction.
REQ-016 Zero input SHALL produce +0 (0x00000000) for both conversions, never -0.
REQ-017 nx SHALL be 1 when guard|sticky is nonzero (the result is inexact), else 0.
- Overflow and NaN are not possible for 32-bit integer inputs.
REQ-018 op=3 SHALL register out=0x00000000 and nx=0.
REQ-019 The block SHALL contain no other state; fcsr rounding mode and flag accumulation are handled outside this block.

Reset
REQ-020 While resetn=1 at a rising edge, out SHALL become 0x00000000 and nx 0, regardless of op/rs1.
REQ-021 An operation presented in the same cycle as reset SHALL be discarded.
REQ-022 In the first cycle after resetn falls, out SHALL show the operation sampled on that edge.

Verification
REQ-023 fclass, one value per cycle:
- 0xFF800000 -> 0x001
- 0x80000000 -> 0x008
- 0x00000001 -> 0x020
- 0x3F800000 -> 0x040
- 0x7F800000 -> 0x080
- 0x7F800001 -> 0x100
- 0xFFC00000 -> 0x200
- each result appears 1 cycle later.
REQ-024 fcvt.s.w exact cases (nx=0):
- 0 -> 0x00000000
- 1 -> 0x3F800000
- -1 -> 0xBF800000
- 0x80000000 -> 0xCF000000
REQ-025 fcvt.s.w rounding cases:
- 16777217 -> 0x4B800000, nx=1 (tie, rounds to even, down)
- 16777219 -> 0x4B800002, nx=1 (tie, rounds up)
- 0x7FFFFFFF -> 0x4F000000, nx=1 (carry into exponent)
REQ-026 fcvt.s.wu:
- 0xFFFFFFFF -> 0x4F800000, nx=1
- 0x80000000 -> 0x4F000000, nx=0
- 3 -> 0x40400000, nx=0
REQ-027 Back-to-back mixed ops on consecutive cycles with a reset pulse inserted mid-stream:
- the cycle after the reset edge shows 0x00000000;
- the following results match their inputs with no stall.
